// File: rtl/edge_detector_multi.sv
// Multi-channel synchronised, debounced edge detector.
// Stretched per-channel pulses, sticky status and a shared irq.
module edge_detector_multi #(
  parameter int WIDTH         = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3,
  parameter int PULSE_LEN     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   din,
  input  logic [2*WIDTH-1:0] mode,
  input  logic [WIDTH-1:0]   clear,
  output logic [WIDTH-1:0]   dout_pulse,
  output logic [WIDTH-1:0]   sticky,
  output logic               irq
);

  localparam int CW =
    (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam int PW = $clog2(PULSE_LEN + 1);

  localparam logic [CW-1:0] CMAX = CW'(FILTER_CYCLES - 1);
  localparam logic [CW-1:0] CONE = CW'(1);
  localparam logic [PW-1:0] PLEN = PW'(PULSE_LEN);
  localparam logic [PW-1:0] PONE = PW'(1);

  logic [WIDTH-1:0] s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = din;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= din;
          for (int k = 1; k < SYNC_STAGES; k++)
            sync_q[k] <= sync_q[k-1];
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  logic [WIDTH-1:0]         filt_q, filt_d;
  logic [WIDTH-1:0]         prev_q, prev_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0][PW-1:0] pcnt_q, pcnt_d;
  logic [WIDTH-1:0]         pulse_q, pulse_d;
  logic [WIDTH-1:0]         sticky_q, sticky_d;
  logic                     irq_q, irq_d;
  logic [WIDTH-1:0]         rise, fall, ev;

  assign rise = filt_q & ~prev_q;
  assign fall = ~filt_q & prev_q;

  always_comb begin
    filt_d   = filt_q;
    cnt_d    = cnt_q;
    pcnt_d   = pcnt_q;
    pulse_d  = pulse_q;
    ev       = '0;
    prev_d   = filt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (s[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CMAX) begin
        filt_d[i] = s[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CONE;
      end

      ev[i] = (mode[2*i]   & rise[i])
            | (mode[2*i+1] & fall[i]);

      // A new event reloads the count, so back-to-back pulses merge.
      if (ev[i]) begin
        pcnt_d[i]  = PLEN;
        pulse_d[i] = 1'b1;
      end else if (pcnt_q[i] > PONE) begin
        pcnt_d[i]  = pcnt_q[i] - PONE;
        pulse_d[i] = 1'b1;
      end else begin
        pcnt_d[i]  = '0;
        pulse_d[i] = 1'b0;
      end
    end
    sticky_d = ev | (sticky_q & ~clear);
    irq_d    = |sticky_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q   <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      pcnt_q   <= '0;
      pulse_q  <= '0;
      sticky_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      filt_q   <= filt_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      pcnt_q   <= pcnt_d;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
      irq_q    <= irq_d;
    end
  end

  assign dout_pulse = pulse_q;
  assign sticky     = sticky_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_edge_detector_multi.sv
// Directed bench for edge_detector_multi.
// dut_a uses PULSE_LEN=2, dut_b PULSE_LEN=5 on shared inputs.
module tb_edge_detector_multi;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] din;
  logic [7:0] mode;
  logic [3:0] clear;
  logic [3:0] pa, sa, pb, sb;
  logic       ia, ib;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  edge_detector_multi #(
    .WIDTH(4), .SYNC_STAGES(2),
    .FILTER_CYCLES(3), .PULSE_LEN(2)
  ) dut_a (
    .clk(clk), .reset(reset), .din(din),
    .mode(mode), .clear(clear),
    .dout_pulse(pa), .sticky(sa), .irq(ia)
  );

  edge_detector_multi #(
    .WIDTH(4), .SYNC_STAGES(2),
    .FILTER_CYCLES(3), .PULSE_LEN(5)
  ) dut_b (
    .clk(clk), .reset(reset), .din(din),
    .mode(mode), .clear(clear),
    .dout_pulse(pb), .sticky(sb), .irq(ib)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic watch(input int n, output logic [3:0] seen);
    seen = '0;
    repeat (n) begin
      @(negedge clk);
      seen |= pa;
    end
  endtask

  logic [3:0] seen;
  logic       hold;

  initial begin
    reset = 1'b1;
    din   = '0;
    mode  = 8'h55;
    clear = '0;
    step(2);
    check("rst_pulse", pa, 4'h0);
    check("rst_sticky", sa, 4'h0);
    check("rst_irq", ia, 1'b0);
    reset = 1'b0;
    step(3);

    // rise on ch0, latency 6 edges, 2-cycle pulse
    din[0] = 1'b1;
    step(5);
    check("rise_early", pa, 4'h0);
    check("rise_early_irq", ia, 1'b0);
    step(1);
    check("rise_p1", pa, 4'h1);
    check("rise_sticky", sa, 4'h1);
    check("rise_irq", ia, 1'b1);
    step(1);
    check("rise_p2", pa, 4'h1);
    step(1);
    check("rise_end", pa, 4'h0);

    din[0] = 1'b0;
    watch(10, seen);
    check("fall_in_rise", seen, 4'h0);
    clear = 4'h1;
    step(1);
    clear = '0;
    check("clr0_sticky", sa, 4'h0);
    check("clr0_irq", ia, 1'b0);

    // fall mode: glitch, then long high, then real fall
    mode = 8'h56;
    din[0] = 1'b1;
    step(2);
    din[0] = 1'b0;
    watch(10, seen);
    check("glitch_pulse", seen, 4'h0);
    check("glitch_sticky", sa, 4'h0);
    din[0] = 1'b1;
    watch(10, seen);
    check("rise_in_fall", seen, 4'h0);
    din[0] = 1'b0;
    step(5);
    check("fall_early", pa, 4'h0);
    step(1);
    check("fall_p1", pa, 4'h1);
    step(1);
    check("fall_p2", pa, 4'h1);
    step(1);
    check("fall_end", pa, 4'h0);
    check("fall_sticky", sa, 4'h1);

    // both mode, ch1 toggles every 4 cycles, PULSE 5 merges
    mode = 8'hFF;
    din[1] = 1'b1;
    hold = 1'b1;
    for (int i = 1; i <= 23; i++) begin
      step(1);
      if (i == 5) check("merge_early", pb[1], 1'b0);
      if (i >= 6 && i <= 22) hold &= pb[1];
      if (i == 4 || i == 8 || i == 12) din[1] = ~din[1];
    end
    check("merge_hold", hold, 1'b1);
    check("merge_end", pb[1], 1'b0);
    check("merge_sticky", sb[1], 1'b1);

    // ch2 sticky: set wins over clear, then clear alone
    din[2] = 1'b1;
    step(8);
    check("ch2_set", sa[2], 1'b1);
    din[2] = 1'b0;
    step(5);
    clear = 4'h4;
    step(1);
    clear = '0;
    check("ch2_ev", pa[2], 1'b1);
    check("ch2_setwins", sa[2], 1'b1);
    step(3);
    clear = 4'hB;
    step(1);
    clear = '0;
    check("clr_others", sa, 4'h4);
    check("clr_others_irq", ia, 1'b1);
    clear = 4'h4;
    step(1);
    clear = '0;
    check("clr2_sticky", sa, 4'h0);
    check("clr2_irq", ia, 1'b0);

    // async reset during ch3 pulse
    mode = 8'h7F;
    din[3] = 1'b1;
    step(6);
    check("ch3_pulse", pa, 4'h8);
    #2 reset = 1'b1;
    #1;
    check("arst_pulse", pa, 4'h0);
    check("arst_sticky", sa, 4'h0);
    check("arst_irq", ia, 1'b0);
    step(2);
    reset = 1'b0;
    step(5);
    check("post_rst_early", pa, 4'h0);
    step(1);
    check("post_rst_pulse", pa, 4'h8);
    check("post_rst_sticky", sa, 4'h8);
    check("post_rst_irq", ia, 1'b1);

    // off mode on ch0, then enable with input already high
    mode = 8'h7C;
    din[0] = 1'b1;
    watch(10, seen);
    check("off_rise", seen[0], 1'b0);
    din[0] = 1'b0;
    watch(10, seen);
    check("off_fall", seen[0], 1'b0);
    check("off_sticky", sa[0], 1'b0);
    din[0] = 1'b1;
    step(10);
    mode = 8'h7D;
    watch(10, seen);
    check("en_high", seen[0], 1'b0);
    din[0] = 1'b0;
    watch(10, seen);
    check("en_fall", seen[0], 1'b0);
    din[0] = 1'b1;
    step(5);
    check("en_early", pa[0], 1'b0);
    step(1);
    check("en_rise", pa[0], 1'b1);
    check("en_sticky", sa[0], 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
